dvi_clk_rst_sequencer: RTL and testbench
========================================

// Module: dvi_clk_rst_sequencer
// PURPOSE
//  Power-up and recovery controller for the DVI output clock tree. Runs on the free-running
//  10 MHz reference clock and watches the CC_PLL lock flag. It gates the 5x serializer
//  domain and the divide-by-5 pixel domain out of reset in a fixed order, and pulses a PLL
//  restart on lock timeout. It also detects lock loss during run and bounds recovery retries.
// PARAMETERS
//  LOCK_STABLE_CYCLES  1000    consecutive synced-lock cycles required before release
//  LOCK_TIMEOUT_CYCLES 100000  cycles in WAIT_LOCK before issuing a PLL restart
//  PLL_RST_CYCLES      8       width of pll_rst_o pulse, cycles
//  STAGE_GAP_CYCLES    16      gap between ser_rst_o and pix_rst_o deassertion, and before video_en_o
//  MAX_RETRIES         3       restarts allowed before FAULT (retry_cnt_o width = 2)
// PORTS
//  clk_i         in   1  10 MHz reference clock (same net as PLL CLK_REF)
//  rst_i         in   1  asynchronous active-high reset
//  pll_lock_i    in   1  PLL locked flag, asynchronous to clk_i
//  clear_fault_i in   1  single-cycle request to leave FAULT and retry from scratch
//  pll_rst_o     out  1  PLL restart request (USR_LOCKED_STDY_RST / PLL reset)
//  ser_rst_o     out  1  active-high reset for 5x serializer domain
//  pix_rst_o     out  1  active-high reset for pixel domain / divider
//  video_en_o    out  1  timing generator enable
//  ready_o       out  1  high only in RUN
//  fault_o       out  1  high only in FAULT
//  retry_cnt_o   out  2  restarts issued since last clean start (saturates at MAX_RETRIES)
//  state_o       out  3  current state encoding (debug)
// BEHAVIOUR
//  - pll_lock_i passes a 2-flop synchronizer (lock_s). All decisions use lock_s.
//  - Reset (async assert, sync release on clk_i): state=PLL_RST, pll_rst_o=1, ser_rst_o=1,
//    pix_rst_o=1, video_en_o=0, ready_o=0, fault_o=0, retry_cnt_o=0, counter=0, lock_s=0.
//  - One shared down/up counter, width clog2(max param)+1. It clears on every state change.
//  - States (state_o code):
//    PLL_RST(0): pll_rst_o=1 for PLL_RST_CYCLES, then go to WAIT_LOCK.
//    WAIT_LOCK(1): count while lock_s=0.
//      - If lock_s=1, go to STABLE.
//      - If the count reaches LOCK_TIMEOUT_CYCLES and retry_cnt<MAX_RETRIES: retry_cnt++, go to PLL_RST.
//      - If the count reaches LOCK_TIMEOUT_CYCLES and retry_cnt=MAX_RETRIES: go to FAULT.
//    STABLE(2): count consecutive lock_s=1 cycles.
//      - Any lock_s=0 goes back to WAIT_LOCK; the timeout count restarts and there is no retry increment.
//      - When the count reaches LOCK_STABLE_CYCLES: ser_rst_o<=0 and go to REL_SER.
//    REL_SER(3): after STAGE_GAP_CYCLES, pix_rst_o<=0 and go to REL_PIX.
//    REL_PIX(4): after STAGE_GAP_CYCLES, video_en_o<=1 and go to RUN.
//    RUN(5): ready_o=1. retry_cnt_o is cleared on entry.
//    FAULT(6): all resets asserted, video_en_o=0, pll_rst_o=1 held. clear_fault_i=1 clears
//      retry_cnt and goes to PLL_RST; otherwise FAULT is held.
//  - Lock loss (lock_s=0) in REL_SER, REL_PIX or RUN: in the same edge, video_en_o<=0,
//    ser_rst_o<=1, pix_rst_o<=1, ready_o<=0.
//      - Then retry_cnt++ and go to PLL_RST.
//      - If retry_cnt=MAX_RETRIES, go to FAULT instead.
//  - Release order is a hard invariant in every cycle:
//      - video_en_o=1 implies pix_rst_o=0.
//      - pix_rst_o=0 implies ser_rst_o=0.
//      - Assertion of all three is simultaneous.
//  - Outputs are registered. Latency from lock_s change to output change is 1 clk_i edge.
//    Latency from pll_lock_i to output is <=3 edges.
//  - clear_fault_i is ignored outside FAULT. rst_i mid-sequence returns to reset values immediately (async).
// TESTING
//  1. Reset release, lock rises 50 cycles after PLL_RST ends, held high.
//     -> ser_rst_o falls 1000 cycles after lock_s.
//     -> pix_rst_o falls 16 cycles later; video_en_o and ready_o rise 16 cycles after that.
//     -> retry_cnt_o=0.
//  2. Lock never asserts -> 3 pll_rst_o pulses of 8 cycles each, spaced 100000+8 cycles.
//     -> fault_o=1 after the 4th timeout, retry_cnt_o=3.
//     -> clear_fault_i pulse gives pll_rst_o 8 cycles, then WAIT_LOCK with retry_cnt_o=0.
//  3. Lock glitches low for 1 cycle at cycle 500 of STABLE -> state returns to WAIT_LOCK.
//     -> No retry increment; ser_rst_o stays 1 until 1000 new stable cycles.
//  4. Lock drops in RUN -> next edge after lock_s=0: video_en_o=0, ser_rst_o=pix_rst_o=1, ready_o=0.
//     -> pll_rst_o pulse follows, retry_cnt_o=1; relock completes the sequence again.
//  5. rst_i asserted mid REL_PIX -> all outputs hit reset values without a clk_i edge.
//     -> The sequence restarts from PLL_RST after release.
//  6. Random lock toggling for 10^6 cycles -> assertion checks confirm release-order invariant never violated.

Source files
------------

// File: rtl/dvi_clk_rst_sequencer.sv
// -----------------------------------------------------------------------------
// dvi_clk_rst_sequencer
// Power-up and recovery controller for the DVI output clock tree. Runs on the
// free-running reference clock and watches the PLL lock flag. It brings the 5x
// serializer domain, then the pixel domain, out of reset, then enables video.
// It pulses a PLL restart on lock timeout or on lock loss after release, and
// bounds the number of restarts before parking in FAULT.
//
// Ports
//   clk_i          reference clock (same net as PLL CLK_REF)
//   rst_i          asynchronous active-high reset
//   pll_lock_i     PLL locked flag, asynchronous to clk_i
//   clear_fault_i  single-cycle request to leave FAULT and retry from scratch
//   pll_rst_o      PLL restart request
//   ser_rst_o      active-high reset for the 5x serializer domain
//   pix_rst_o      active-high reset for the pixel domain / divider
//   video_en_o     timing generator enable
//   ready_o        high only in RUN
//   fault_o        high only in FAULT
//   retry_cnt_o    restarts issued since last clean start (saturating)
//   state_o        current state encoding (debug)
// -----------------------------------------------------------------------------
module dvi_clk_rst_sequencer #(
    parameter int unsigned LOCK_STABLE_CYCLES  = 1000,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 100000,
    parameter int unsigned PLL_RST_CYCLES      = 8,
    parameter int unsigned STAGE_GAP_CYCLES    = 16,
    parameter int unsigned MAX_RETRIES         = 3
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       pll_lock_i,
    input  logic       clear_fault_i,
    output logic       pll_rst_o,
    output logic       ser_rst_o,
    output logic       pix_rst_o,
    output logic       video_en_o,
    output logic       ready_o,
    output logic       fault_o,
    output logic [1:0] retry_cnt_o,
    output logic [2:0] state_o
);

    // Counter sized for the largest interval it has to measure
    localparam int unsigned MAX_A = (LOCK_STABLE_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                                    LOCK_STABLE_CYCLES : LOCK_TIMEOUT_CYCLES;
    localparam int unsigned MAX_B = (PLL_RST_CYCLES > STAGE_GAP_CYCLES) ?
                                    PLL_RST_CYCLES : STAGE_GAP_CYCLES;
    localparam int unsigned MAX_P = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned CNT_W = $clog2(MAX_P) + 1;

    // Terminal counts: the counter starts at 0 on state entry, so the last
    // cycle of an N-cycle interval is N-1.
    localparam logic [CNT_W-1:0] PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(STAGE_GAP_CYCLES - 1);
    localparam logic [1:0]       RETRY_MAX    = 2'(MAX_RETRIES);

    typedef enum logic [2:0] {
        ST_PLL_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_REL_SER   = 3'd3,
        ST_REL_PIX   = 3'd4,
        ST_RUN       = 3'd5,
        ST_FAULT     = 3'd6
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [1:0]         r_retry;
    logic [1:0]         w_retry_nxt;
    logic               r_lock_meta;
    logic               r_lock_s;

    logic               r_pll_rst;
    logic               r_ser_rst;
    logic               r_pix_rst;
    logic               r_video_en;
    logic               r_ready;
    logic               r_fault;

    logic               w_pll_rst_nxt;
    logic               w_ser_rst_nxt;
    logic               w_pix_rst_nxt;
    logic               w_video_en_nxt;
    logic               w_ready_nxt;
    logic               w_fault_nxt;

    // Two-flop synchronizer for the asynchronous lock flag
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_lock_meta <= 1'b0;
            r_lock_s    <= 1'b0;
        end else begin
            r_lock_meta <= pll_lock_i;
            r_lock_s    <= r_lock_meta;
        end
    end

    // State, shared counter and retry count
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_PLL_RST;
            r_cnt   <= '0;
            r_retry <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_retry <= w_retry_nxt;
        end
    end

    // Next-state, counter and retry logic
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + CNT_W'(1);
        w_retry_nxt = r_retry;

        unique case (r_state)
            ST_PLL_RST: begin
                if (r_cnt == PLL_RST_LAST) begin
                    w_state_nxt = ST_WAIT_LOCK;
                end
            end

            ST_WAIT_LOCK: begin
                if (r_lock_s) begin
                    w_state_nxt = ST_STABLE;
                end else if (r_cnt == TIMEOUT_LAST) begin
                    if (r_retry == RETRY_MAX) begin
                        w_state_nxt = ST_FAULT;
                    end else begin
                        w_retry_nxt = r_retry + 2'd1;
                        w_state_nxt = ST_PLL_RST;
                    end
                end
            end

            // A lock drop here is a glitch before release: restart the wait
            // without spending a retry.
            ST_STABLE: begin
                if (!r_lock_s) begin
                    w_state_nxt = ST_WAIT_LOCK;
                end else if (r_cnt == STABLE_LAST) begin
                    w_state_nxt = ST_REL_SER;
                end
            end

            ST_REL_SER, ST_REL_PIX, ST_RUN: begin
                if (!r_lock_s) begin
                    // Lock lost after release: recover via a PLL restart
                    if (r_retry == RETRY_MAX) begin
                        w_state_nxt = ST_FAULT;
                    end else begin
                        w_retry_nxt = r_retry + 2'd1;
                        w_state_nxt = ST_PLL_RST;
                    end
                end else if (r_state == ST_REL_SER) begin
                    if (r_cnt == GAP_LAST) begin
                        w_state_nxt = ST_REL_PIX;
                    end
                end else if (r_state == ST_REL_PIX) begin
                    if (r_cnt == GAP_LAST) begin
                        w_state_nxt = ST_RUN;
                        w_retry_nxt = 2'd0;
                    end
                end else begin
                    w_cnt_nxt = r_cnt;
                end
            end

            ST_FAULT: begin
                w_cnt_nxt = r_cnt;
                if (clear_fault_i) begin
                    w_retry_nxt = 2'd0;
                    w_state_nxt = ST_PLL_RST;
                end
            end

            default: begin
                w_state_nxt = ST_PLL_RST;
            end
        endcase

        if (w_state_nxt != r_state) begin
            w_cnt_nxt = '0;
        end
    end

    // Outputs decoded from the next state so the registered copies line up
    // with the state register. Reset release order holds by construction.
    always_comb begin
        w_pll_rst_nxt  = 1'b0;
        w_ser_rst_nxt  = 1'b1;
        w_pix_rst_nxt  = 1'b1;
        w_video_en_nxt = 1'b0;
        w_ready_nxt    = 1'b0;
        w_fault_nxt    = 1'b0;

        unique case (w_state_nxt)
            ST_PLL_RST: begin
                w_pll_rst_nxt = 1'b1;
            end
            ST_REL_SER: begin
                w_ser_rst_nxt = 1'b0;
            end
            ST_REL_PIX: begin
                w_ser_rst_nxt = 1'b0;
                w_pix_rst_nxt = 1'b0;
            end
            ST_RUN: begin
                w_ser_rst_nxt  = 1'b0;
                w_pix_rst_nxt  = 1'b0;
                w_video_en_nxt = 1'b1;
                w_ready_nxt    = 1'b1;
            end
            ST_FAULT: begin
                w_pll_rst_nxt = 1'b1;
                w_fault_nxt   = 1'b1;
            end
            default: begin
                w_pll_rst_nxt = 1'b0;
            end
        endcase
    end

    // Registered outputs
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_pll_rst  <= 1'b1;
            r_ser_rst  <= 1'b1;
            r_pix_rst  <= 1'b1;
            r_video_en <= 1'b0;
            r_ready    <= 1'b0;
            r_fault    <= 1'b0;
        end else begin
            r_pll_rst  <= w_pll_rst_nxt;
            r_ser_rst  <= w_ser_rst_nxt;
            r_pix_rst  <= w_pix_rst_nxt;
            r_video_en <= w_video_en_nxt;
            r_ready    <= w_ready_nxt;
            r_fault    <= w_fault_nxt;
        end
    end

    assign pll_rst_o   = r_pll_rst;
    assign ser_rst_o   = r_ser_rst;
    assign pix_rst_o   = r_pix_rst;
    assign video_en_o  = r_video_en;
    assign ready_o     = r_ready;
    assign fault_o     = r_fault;
    assign retry_cnt_o = r_retry;
    assign state_o     = r_state;

endmodule

// File: tb/tb_dvi_clk_rst_sequencer.sv
// -----------------------------------------------------------------------------
// tb_dvi_clk_rst_sequencer
// Scenario bench for the DVI clock/reset sequencer, run with shortened
// intervals. Directed scenarios check timing against arithmetic expectations;
// a random lock-toggling run is compared cycle by cycle to a reference model.
// -----------------------------------------------------------------------------
module tb_dvi_clk_rst_sequencer;

    localparam int unsigned STABLE_N  = 40;
    localparam int unsigned TIMEOUT_N = 200;
    localparam int unsigned PLLRST_N  = 8;
    localparam int unsigned GAP_N     = 16;
    localparam int unsigned RETRY_N   = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       pll_lock;
    logic       clear_fault;
    logic       pll_rst_o;
    logic       ser_rst_o;
    logic       pix_rst_o;
    logic       video_en_o;
    logic       ready_o;
    logic       fault_o;
    logic [1:0] retry_cnt_o;
    logic [2:0] state_o;

    int errors = 0;
    int checks = 0;

    dvi_clk_rst_sequencer #(
        .LOCK_STABLE_CYCLES  (STABLE_N),
        .LOCK_TIMEOUT_CYCLES (TIMEOUT_N),
        .PLL_RST_CYCLES      (PLLRST_N),
        .STAGE_GAP_CYCLES    (GAP_N),
        .MAX_RETRIES         (RETRY_N)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .pll_lock_i    (pll_lock),
        .clear_fault_i (clear_fault),
        .pll_rst_o     (pll_rst_o),
        .ser_rst_o     (ser_rst_o),
        .pix_rst_o     (pix_rst_o),
        .video_en_o    (video_en_o),
        .ready_o       (ready_o),
        .fault_o       (fault_o),
        .retry_cnt_o   (retry_cnt_o),
        .state_o       (state_o)
    );

    always #5 clk = ~clk;

    // {pll, ser, pix, video, ready, fault, retry[1:0], state[2:0]}
    localparam logic [10:0] RESET_VEC = 11'b111_000_00_000;

    function automatic logic [10:0] obs_vec();
        return {pll_rst_o, ser_rst_o, pix_rst_o, video_en_o, ready_o, fault_o,
                retry_cnt_o, state_o};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic lock_val);
        rst = 1'b1;
        pll_lock = lock_val;
        clear_fault = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        pll_lock = 1'b0;
        clear_fault = 1'b0;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        checks++;
        if (obs_vec() !== RESET_VEC) begin
            errors++;
            $display("FAIL reset_values: got %b expected %b", obs_vec(), RESET_VEC);
        end
        tick();
        rst = 1'b0;
    endtask

    // Clean power-up: lock rises 50 cycles after PLL reset ends.
    task automatic test_power_up();
        int n;
        do_reset(1'b0);
        n = 0;
        do begin tick(); n++; end while (pll_rst_o !== 1'b0 && n < 100);
        checks++;
        if (n != PLLRST_N) begin
            errors++; $display("FAIL pll_rst_width: got %0d expected %0d", n, PLLRST_N);
        end
        repeat (50) tick();
        pll_lock = 1'b1;
        n = 0;
        do begin tick(); n++; end while (ser_rst_o !== 1'b0 && n < 1000);
        checks++;
        // 2 sync stages + 1 edge into STABLE + STABLE_N counted cycles
        if (n != int'(STABLE_N) + 3) begin
            errors++; $display("FAIL ser_release_delay: got %0d expected %0d", n, STABLE_N + 3);
        end
        n = 0;
        do begin tick(); n++; end while (pix_rst_o !== 1'b0 && n < 1000);
        checks++;
        if (n != GAP_N || ser_rst_o !== 1'b0) begin
            errors++; $display("FAIL pix_release_delay: got %0d expected %0d", n, GAP_N);
        end
        n = 0;
        do begin tick(); n++; end while (video_en_o !== 1'b1 && n < 1000);
        checks++;
        if (n != GAP_N) begin
            errors++; $display("FAIL video_en_delay: got %0d expected %0d", n, GAP_N);
        end
        checks++;
        if (ready_o !== 1'b1 || state_o !== 3'd5 || retry_cnt_o !== 2'd0 || fault_o !== 1'b0) begin
            errors++;
            $display("FAIL run_outputs: ready=%b state=%0d retry=%0d fault=%b expected 1/5/0/0",
                     ready_o, state_o, retry_cnt_o, fault_o);
        end
    endtask

    // Lock drops while in RUN, then comes back.
    task automatic test_lock_loss_run();
        int n;
        pll_lock = 1'b0;
        n = 0;
        do begin tick(); n++; end while (ready_o !== 1'b0 && n < 100);
        checks++;
        if (n != 3) begin
            errors++; $display("FAIL loss_latency: got %0d expected 3", n);
        end
        checks++;
        if ({video_en_o, ser_rst_o, pix_rst_o, pll_rst_o, retry_cnt_o, state_o} !== 9'b0111_01_000) begin
            errors++;
            $display("FAIL loss_outputs: got %b expected %b",
                     {video_en_o, ser_rst_o, pix_rst_o, pll_rst_o, retry_cnt_o, state_o}, 9'b0111_01_000);
        end
        pll_lock = 1'b1;
        n = 0;
        do begin tick(); n++; end while (pll_rst_o !== 1'b0 && n < 100);
        checks++;
        if (n != PLLRST_N || retry_cnt_o !== 2'd1) begin
            errors++; $display("FAIL loss_pll_pulse: width=%0d retry=%0d expected %0d/1", n, retry_cnt_o, PLLRST_N);
        end
        n = 0;
        do begin tick(); n++; end while (ready_o !== 1'b1 && n < 1000);
        checks++;
        if (n != int'(STABLE_N + 2 * GAP_N) + 1 || retry_cnt_o !== 2'd0) begin
            errors++;
            $display("FAIL relock_run: delay=%0d retry=%0d expected %0d/0", n, retry_cnt_o,
                     STABLE_N + 2 * GAP_N + 1);
        end
    endtask

    // Lock glitches low for one cycle in the middle of STABLE.
    task automatic test_glitch();
        int  n;
        bit  saw_wait;
        bit  retry_moved;
        do_reset(1'b0);
        n = 0;
        do begin tick(); n++; end while (state_o !== 3'd1 && n < 100);
        pll_lock = 1'b1;
        n = 0;
        do begin tick(); n++; end while (state_o !== 3'd2 && n < 100);
        repeat (STABLE_N / 2) tick();
        pll_lock = 1'b0;
        n = 0;
        saw_wait = 1'b0;
        retry_moved = 1'b0;
        do begin
            tick(); n++;
            if (n == 1) pll_lock = 1'b1;
            if (state_o === 3'd1) saw_wait = 1'b1;
            if (retry_cnt_o !== 2'd0) retry_moved = 1'b1;
        end while (ser_rst_o !== 1'b0 && n < 1000);
        checks++;
        if (!saw_wait || retry_moved) begin
            errors++; $display("FAIL glitch_path: saw_wait=%0d retry_moved=%0d expected 1/0", saw_wait, retry_moved);
        end
        checks++;
        // glitch reaches FSM 3 edges later, 1 edge back to STABLE, then full count
        if (n != int'(STABLE_N) + 4) begin
            errors++; $display("FAIL glitch_restart: got %0d expected %0d", n, STABLE_N + 4);
        end
    endtask

    // Lock never asserts: retries exhaust into FAULT, then clear_fault.
    task automatic test_timeout_fault();
        int n;
        int rises;
        int last_rise;
        int bad_gap;
        logic prev_pll;
        do_reset(1'b0);
        n = 0; rises = 0; last_rise = 0; bad_gap = 0; prev_pll = 1'b1;
        do begin
            tick(); n++;
            if (pll_rst_o === 1'b1 && prev_pll === 1'b0 && fault_o !== 1'b1) begin
                rises++;
                if (n - last_rise != int'(TIMEOUT_N + PLLRST_N)) bad_gap++;
                if (retry_cnt_o !== 2'(rises)) bad_gap++;
                last_rise = n;
            end
            prev_pll = pll_rst_o;
        end while (fault_o !== 1'b1 && n < 2000);
        checks++;
        if (n != int'((RETRY_N + 1) * (TIMEOUT_N + PLLRST_N))) begin
            errors++; $display("FAIL fault_time: got %0d expected %0d", n, (RETRY_N + 1) * (TIMEOUT_N + PLLRST_N));
        end
        checks++;
        if (rises != int'(RETRY_N) || bad_gap != 0) begin
            errors++; $display("FAIL retry_pulses: rises=%0d bad=%0d expected %0d/0", rises, bad_gap, RETRY_N);
        end
        checks++;
        if ({pll_rst_o, ser_rst_o, pix_rst_o, video_en_o, retry_cnt_o, state_o} !== 9'b1110_11_110) begin
            errors++;
            $display("FAIL fault_outputs: got %b expected %b",
                     {pll_rst_o, ser_rst_o, pix_rst_o, video_en_o, retry_cnt_o, state_o}, 9'b1110_11_110);
        end
        repeat (5) tick();
        checks++;
        if (fault_o !== 1'b1) begin
            errors++; $display("FAIL fault_hold: got %b expected 1", fault_o);
        end
        clear_fault = 1'b1;
        n = 0;
        do begin tick(); n++; clear_fault = 1'b0; end while (pll_rst_o !== 1'b0 && n < 100);
        checks++;
        if (n != int'(PLLRST_N) + 1 || state_o !== 3'd1 || retry_cnt_o !== 2'd0 || fault_o !== 1'b0) begin
            errors++;
            $display("FAIL clear_fault: delay=%0d state=%0d retry=%0d expected %0d/1/0",
                     n, state_o, retry_cnt_o, PLLRST_N + 1);
        end
        clear_fault = 1'b1;
        tick();
        clear_fault = 1'b0;
        tick();
        checks++;
        if (state_o !== 3'd1 || pll_rst_o !== 1'b0) begin
            errors++; $display("FAIL clear_ignored: state=%0d pll=%b expected 1/0", state_o, pll_rst_o);
        end
    endtask

    // Async reset in the middle of REL_PIX.
    task automatic test_rst_mid();
        int n;
        do_reset(1'b1);
        n = 0;
        do begin tick(); n++; end while (state_o !== 3'd4 && n < 500);
        repeat (5) tick();
        rst = 1'b1;
        #1;
        checks++;
        if (obs_vec() !== RESET_VEC) begin
            errors++; $display("FAIL async_reset: got %b expected %b", obs_vec(), RESET_VEC);
        end
        tick();
        rst = 1'b0;
        n = 0;
        do begin tick(); n++; end while (state_o !== 3'd1 && n < 100);
        checks++;
        if (n != PLLRST_N) begin
            errors++; $display("FAIL restart_after_reset: got %0d expected %0d", n, PLLRST_N);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: phase follows the state_o codes, m_time counts the
    // cycles already completed in the phase.
    int   m_phase, m_time, m_retry;
    logic m_sync1, m_sync2;

    function automatic void model_reset();
        m_phase = 0; m_time = 0; m_retry = 0; m_sync1 = 1'b0; m_sync2 = 1'b0;
    endfunction

    function automatic void model_enter(input int p);
        m_phase = p;
        m_time = 0;
    endfunction

    function automatic void model_loss();
        if (m_retry >= int'(RETRY_N)) model_enter(6);
        else begin m_retry++; model_enter(0); end
    endfunction

    function automatic void model_step(input logic lock_in, input logic clr_in);
        logic locked;
        int   limit;
        locked = m_sync2;
        case (m_phase)
            0: limit = int'(PLLRST_N);
            1: limit = int'(TIMEOUT_N);
            2: limit = int'(STABLE_N);
            default: limit = int'(GAP_N);
        endcase
        case (m_phase)
            0: if (m_time + 1 >= limit) model_enter(1); else m_time++;
            1: if (locked) model_enter(2);
               else if (m_time + 1 >= limit) begin
                   if (m_retry >= int'(RETRY_N)) model_enter(6);
                   else begin m_retry++; model_enter(0); end
               end else m_time++;
            2: if (!locked) model_enter(1);
               else if (m_time + 1 >= limit) model_enter(3); else m_time++;
            3, 4: if (!locked) model_loss();
               else if (m_time + 1 >= limit) begin
                   if (m_phase == 4) m_retry = 0;
                   model_enter(m_phase + 1);
               end else m_time++;
            5: if (!locked) model_loss();
            default: if (clr_in) begin m_retry = 0; model_enter(0); end
        endcase
        m_sync2 = m_sync1;
        m_sync1 = lock_in;
    endfunction

    function automatic logic [10:0] model_vec();
        logic pll, ser, pix, ven, rdy, flt;
        pll = (m_phase == 0 || m_phase == 6);
        ser = !(m_phase >= 3 && m_phase <= 5);
        pix = !(m_phase == 4 || m_phase == 5);
        ven = (m_phase == 5);
        rdy = (m_phase == 5);
        flt = (m_phase == 6);
        return {pll, ser, pix, ven, rdy, flt, 2'(m_retry), 3'(m_phase)};
    endfunction

    task automatic test_random();
        int   dwell;
        int   order_bad;
        int   mism;
        int   runs;
        logic lk, cf;
        do_reset(1'b0);
        model_reset();
        lk = 1'b0; dwell = 0; order_bad = 0; mism = 0; runs = 0;
        for (int c = 0; c < 30000 && mism == 0; c++) begin
            if (dwell == 0) begin
                lk = ~lk;
                dwell = lk ? int'($urandom_range(1, 150)) : int'($urandom_range(1, 260));
            end
            dwell--;
            cf = ($urandom_range(0, 19) == 0);
            pll_lock = lk;
            clear_fault = cf;
            tick();
            model_step(lk, cf);
            if (state_o === 3'd5) runs++;
            if ((video_en_o && pix_rst_o) || (!pix_rst_o && ser_rst_o)) order_bad++;
            checks++;
            if (obs_vec() !== model_vec()) begin
                errors++; mism++;
                $display("FAIL random_cycle_%0d: got %b expected %b", c, obs_vec(), model_vec());
            end
        end
        clear_fault = 1'b0;
        checks++;
        if (order_bad != 0) begin
            errors++; $display("FAIL release_order: violations=%0d expected 0", order_bad);
        end
        if (runs == 0) $display("note: random run never reached RUN");
    endtask

    initial begin
        rst = 1'b1;
        pll_lock = 1'b0;
        clear_fault = 1'b0;
        test_reset();
        test_power_up();
        test_lock_loss_run();
        test_glitch();
        test_timeout_fault();
        test_rst_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
